// File: rtl/baccarat_round_fsm.sv
// Baccarat round controller: deal strobes, third-card rules, win lights.
// Optional outcome tallies are built when ROUND_TALLY_EN is defined.
module baccarat_round_fsm #(
   parameter int TALLY_W = 8
) (
   input  logic               slow_clock,
   input  logic               resetb,
   input  logic               step,
   input  logic [3:0]         pscore,
   input  logic [3:0]         dscore,
   input  logic [3:0]         pcard3,
   output logic               load_pcard1,
   output logic               load_pcard2,
   output logic               load_pcard3,
   output logic               load_dcard1,
   output logic               load_dcard2,
   output logic               load_dcard3,
   output logic               new_hand,
   output logic               player_win_light,
   output logic               dealer_win_light,
   output logic               hand_done,
   output logic [TALLY_W-1:0] player_tally,
   output logic [TALLY_W-1:0] dealer_tally,
   output logic [TALLY_W-1:0] tie_tally
);

   typedef enum logic [3:0] {
      DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2, EVAL,
      DEAL_P3, BANK_EVAL, DEAL_D3, RESULT, DONE
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] v3;
   logic       bank_draw;

   // Face cards and tens count as zero toward the banker rule.
   assign v3 = (pcard3 <= 4'd9) ? pcard3 : 4'd0;

   always_comb begin
      case (dscore)
         4'd0, 4'd1, 4'd2: bank_draw = 1'b1;
         4'd3:             bank_draw = (v3 != 4'd8);
         4'd4:             bank_draw = (v3 >= 4'd2) && (v3 <= 4'd7);
         4'd5:             bank_draw = (v3 >= 4'd4) && (v3 <= 4'd7);
         4'd6:             bank_draw = (v3 >= 4'd6) && (v3 <= 4'd7);
         default:          bank_draw = 1'b0;
      endcase
   end

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) state <= DEAL_P1;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      load_pcard1 = 1'b0;
      load_pcard2 = 1'b0;
      load_pcard3 = 1'b0;
      load_dcard1 = 1'b0;
      load_dcard2 = 1'b0;
      load_dcard3 = 1'b0;
      new_hand    = 1'b0;
      hand_done   = 1'b0;
      if (resetb) begin
         hand_done = (state == DONE);
         if (step) begin
            case (state)
               DEAL_P1: begin load_pcard1 = 1'b1; state_nxt = DEAL_D1; end
               DEAL_D1: begin load_dcard1 = 1'b1; state_nxt = DEAL_P2; end
               DEAL_P2: begin load_pcard2 = 1'b1; state_nxt = DEAL_D2; end
               DEAL_D2: begin load_dcard2 = 1'b1; state_nxt = EVAL;    end
               EVAL: begin
                  if (pscore >= 4'd8 || dscore >= 4'd8) state_nxt = RESULT;
                  else if (pscore <= 4'd5)              state_nxt = DEAL_P3;
                  else if (dscore <= 4'd5)              state_nxt = DEAL_D3;
                  else                                  state_nxt = RESULT;
               end
               DEAL_P3:   begin load_pcard3 = 1'b1; state_nxt = BANK_EVAL; end
               BANK_EVAL: state_nxt = bank_draw ? DEAL_D3 : RESULT;
               DEAL_D3:   begin load_dcard3 = 1'b1; state_nxt = RESULT; end
               RESULT:    state_nxt = DONE;
               DONE:      begin new_hand = 1'b1; state_nxt = DEAL_P1; end
               default:   state_nxt = DEAL_P1;
            endcase
         end
      end
   end

   // A tie lights both lamps; DONE+step starts a fresh hand with lamps dark.
   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         player_win_light <= 1'b0;
         dealer_win_light <= 1'b0;
      end else if (step && state == RESULT) begin
         player_win_light <= (pscore >= dscore);
         dealer_win_light <= (dscore >= pscore);
      end else if (step && state == DONE) begin
         player_win_light <= 1'b0;
         dealer_win_light <= 1'b0;
      end
   end

`ifdef ROUND_TALLY_EN
   localparam logic [TALLY_W-1:0] TALLY_MAX = '1;
   logic result_edge;
   assign result_edge = step && (state == RESULT);

   always_ff @(posedge slow_clock or negedge resetb) begin
      if (!resetb) begin
         player_tally <= '0;
         dealer_tally <= '0;
         tie_tally    <= '0;
      end else if (result_edge) begin
         if (pscore > dscore && player_tally != TALLY_MAX)
            player_tally <= player_tally + 1'b1;
         if (dscore > pscore && dealer_tally != TALLY_MAX)
            dealer_tally <= dealer_tally + 1'b1;
         if (pscore == dscore && tie_tally != TALLY_MAX)
            tie_tally <= tie_tally + 1'b1;
      end
   end
`else
   assign player_tally = '0;
   assign dealer_tally = '0;
   assign tie_tally    = '0;
`endif

endmodule

// File: tb/tb_baccarat_round_fsm.sv
// Scoreboard bench for baccarat_round_fsm; tally expectations follow ROUND_TALLY_EN.
module tb_baccarat_round_fsm;

   localparam int TW = 8;
   localparam int TMAX = (1 << TW) - 1;

   logic          slow_clock = 1'b0;
   logic          resetb = 1'b0;
   logic          step = 1'b0;
   logic [3:0]    pscore = '0, dscore = '0, pcard3 = '0;
   logic          load_pcard1, load_pcard2, load_pcard3;
   logic          load_dcard1, load_dcard2, load_dcard3;
   logic          new_hand, player_win_light, dealer_win_light, hand_done;
   logic [TW-1:0] player_tally, dealer_tally, tie_tally;

   baccarat_round_fsm #(.TALLY_W(TW)) dut (
      .slow_clock(slow_clock), .resetb(resetb), .step(step),
      .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
      .load_pcard1(load_pcard1), .load_pcard2(load_pcard2), .load_pcard3(load_pcard3),
      .load_dcard1(load_dcard1), .load_dcard2(load_dcard2), .load_dcard3(load_dcard3),
      .new_hand(new_hand), .player_win_light(player_win_light),
      .dealer_win_light(dealer_win_light), .hand_done(hand_done),
      .player_tally(player_tally), .dealer_tally(dealer_tally), .tie_tally(tie_tally)
   );

   always #5 slow_clock = ~slow_clock;

   typedef struct {
      int p3, d3, pw, dw, edges;
   } exp_t;

   exp_t sb[$];
   int   checks = 0, errors = 0;
   int   ep = 0, ed = 0, et = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int strobes();
      return int'(load_pcard1) + int'(load_pcard2) + int'(load_pcard3) +
             int'(load_dcard1) + int'(load_dcard2) + int'(load_dcard3);
   endfunction

   function automatic int bank_rule(input int d, input int r);
      int v;
      v = (r <= 9) ? r : 0;
      if (d <= 2) return 1;
      if (d == 3) return int'(v != 8);
      if (d == 4) return int'(v >= 2 && v <= 7);
      if (d == 5) return int'(v >= 4 && v <= 7);
      if (d == 6) return int'(v >= 6 && v <= 7);
      return 0;
   endfunction

   function automatic int sat(input int x);
      return (x >= TMAX) ? TMAX : x + 1;
   endfunction

   task automatic check_tallies(input string tag);
      chk({tag, "_ptally"}, int'(player_tally), ep);
      chk({tag, "_dtally"}, int'(dealer_tally), ed);
      chk({tag, "_ttally"}, int'(tie_tally), et);
   endtask

   // Plays one hand up to DONE. Final scores are presented once the matching
   // third card has been loaded, as the scorers would do.
   task automatic run_hand(input int p2, input int d2, input int pc3,
                           input int pf, input int df, input int hold_at);
      exp_t e, got;
      int   nat, fp, fd, edges, maxs, nh, sp3, sd3, done;
      nat = int'(p2 >= 8 || d2 >= 8);
      e.p3 = int'(!nat && p2 <= 5);
      e.d3 = nat ? 0 : (e.p3 ? bank_rule(d2, pc3) : int'(d2 <= 5));
      fp = e.p3 ? pf : p2;
      fd = e.d3 ? df : d2;
      e.pw = int'(fp >= fd);
      e.dw = int'(fd >= fp);
      e.edges = 6 + 2 * e.p3 + e.d3;
      sb.push_back(e);

      pscore = 4'(p2); dscore = 4'(d2); pcard3 = 4'(pc3);
      edges = 0; maxs = 0; nh = 0; sp3 = 0; sd3 = 0; done = 0;
      for (int n = 0; n < 20 && done == 0; n++) begin
         @(negedge slow_clock);
         step = 1'b1;
         #1;
         if (strobes() > maxs) maxs = strobes();
         nh += int'(new_hand);
         if (hold_at > 0 && edges == hold_at) chk("post_hold_pcard2", int'(load_pcard2), 1);
         sp3 += int'(load_pcard3);
         sd3 += int'(load_dcard3);
         @(posedge slow_clock);
         #1;
         edges++;
         if (load_pcard3) pscore = 4'(pf);
         if (load_dcard3) dscore = 4'(df);
         step = 1'b0;
         if (hand_done) done = 1;
         if (hold_at > 0 && edges == hold_at) begin
            int s = 0;
            repeat (5) begin
               @(negedge slow_clock);
               #1;
               s += strobes() + int'(new_hand) + int'(hand_done);
            end
            chk("hold_strobes", s, 0);
         end
      end

      got = sb.pop_front();
      chk("hand_done", int'(hand_done), 1);
      chk("edges", edges, got.edges);
      chk("load_pcard3", sp3, got.p3);
      chk("load_dcard3", sd3, got.d3);
      chk("max_strobes", maxs, 1);
      chk("new_hand_mid", nh, 0);
      chk("player_light", int'(player_win_light), got.pw);
      chk("dealer_light", int'(dealer_win_light), got.dw);
`ifdef ROUND_TALLY_EN
      if (got.pw == 1 && got.dw == 0) ep = sat(ep);
      if (got.dw == 1 && got.pw == 0) ed = sat(ed);
      if (got.pw == 1 && got.dw == 1) et = sat(et);
`endif
      check_tallies("hand");
      repeat (3) @(negedge slow_clock);
      chk("hold_player_light", int'(player_win_light), got.pw);
      chk("hold_dealer_light", int'(dealer_win_light), got.dw);
   endtask

   task automatic finish_hand();
      @(negedge slow_clock);
      step = 1'b1;
      #1;
      chk("new_hand", int'(new_hand), 1);
      @(posedge slow_clock);
      #1;
      step = 1'b0;
      chk("clr_player_light", int'(player_win_light), 0);
      chk("clr_dealer_light", int'(dealer_win_light), 0);
      chk("clr_hand_done", int'(hand_done), 0);
   endtask

   task automatic do_reset();
      resetb = 1'b0;
      ep = 0; ed = 0; et = 0;
      #1;
      chk("rst_player_light", int'(player_win_light), 0);
      chk("rst_dealer_light", int'(dealer_win_light), 0);
      chk("rst_hand_done", int'(hand_done), 0);
      check_tallies("rst");
      @(negedge slow_clock);
      resetb = 1'b1;
   endtask

   initial begin
      // Strobes must stay low under reset even with step high.
      step = 1'b1;
      #2;
      chk("rst_strobes", strobes() + int'(new_hand), 0);
      step = 1'b0;
      do_reset();

      run_hand(8, 3, 0, 0, 0, 0);   finish_hand();   // player natural
      run_hand(4, 7, 6, 0, 0, 0);   finish_hand();   // player draws, banker 7 stands
      run_hand(5, 6, 7, 2, 9, 0);   finish_hand();   // banker 6 draws on 7
      run_hand(5, 6, 8, 2, 9, 0);   finish_hand();   // banker 6 stands on 8
      run_hand(5, 6, 12, 2, 9, 0);  finish_hand();   // face card counts as 0
      run_hand(6, 5, 0, 0, 6, 0);   finish_hand();   // player stands, tie 6-6
      run_hand(3, 3, 8, 7, 1, 0);   finish_hand();   // banker 3 stands on 8
      run_hand(2, 4, 3, 9, 7, 2);   finish_hand();   // pause in DEAL_P2

      // Abort in DEAL_P3: straight back to DEAL_P1.
      pscore = 4'd4; dscore = 4'd7; pcard3 = 4'd6;
      repeat (5) begin
         @(negedge slow_clock); step = 1'b1;
         @(posedge slow_clock); #1; step = 1'b0;
      end
      @(negedge slow_clock);
      step = 1'b1;
      #1;
      chk("in_deal_p3", int'(load_pcard3), 1);
      resetb = 1'b0;
      ep = 0; ed = 0; et = 0;
      #1;
      chk("abort_strobes", strobes(), 0);
      chk("abort_player_light", int'(player_win_light), 0);
      check_tallies("abort");
      step = 1'b0;
      @(negedge slow_clock);
      resetb = 1'b1;
      step = 1'b1;
      #1;
      chk("abort_restart_pcard1", int'(load_pcard1), 1);
      step = 1'b0;

      // Reset while lamps are lit in DONE.
      run_hand(9, 1, 0, 0, 0, 0);
      do_reset();

      // Long run of player naturals to reach tally saturation.
      for (int i = 0; i < 256; i++) begin
         run_hand(9, 2, 0, 0, 0, 0);
         finish_hand();
      end
      run_hand(1, 8, 0, 0, 0, 0);  finish_hand();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
